ps2_action_decoder: RTL
=======================

PS2_ACTION_DECODER -- requirements
Module: ps2_action_decoder

Interface
REQ-001 Parameter N_ACT, default 5: number of mapped action keys.
REQ-002 Parameter KEY_CODES, default {8'h4C,8'h4B,8'h22,8'h21,8'h4D}, width N_ACT*8: scan code of action i in bits [8i+7:8i].
REQ-003 Parameter FILT_LEN, default 4: consecutive equal samples needed to accept a Ps2Clk level.
REQ-004 Parameter TIMEOUT_CYC, default 50000: ClockT cycles allowed between Ps2Clk falling edges inside a frame.
REQ-005 Parameter FIFO_DEPTH, default 4, power of two: event queue depth.
REQ-006 ClockT  in  1  system clock; the block has exactly one clock, and every flop is clocked on the ClockT rising edge.
REQ-007 Reset  in  1  asynchronous, active-high reset.
REQ-008 Ps2Clk  in  1  raw PS/2 clock, asynchronous to ClockT.
REQ-009 DataT  in  1  raw PS/2 data, asynchronous to ClockT.
REQ-010 mAccion  out  N_ACT  level: bit i is 1 while mapped key i is held.
REQ-011 bandera  out  1  one-cycle pulse when a mapped key goes from released to pressed.
REQ-012 evt_valid  out  1  event queue not empty.
REQ-013 evt_data  out  10  head event {brk, ext, code[7:0]}.
REQ-014 evt_ready  in  1  pop the head event when evt_valid=1.
REQ-015 err_frame  out  1  one-cycle pulse on a start, parity, stop or timeout error.
REQ-016 ovf  out  1  sticky flag: an event was dropped.

Function
REQ-017 Ps2Clk and DataT SHALL each pass through a 2-flop synchronizer.
REQ-018 The filtered Ps2Clk SHALL change only after FILT_LEN equal synchronized samples; a falling edge of the filtered clock is the sample strobe.
REQ-019 Frame FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: on strobe with DataT=0, go to DATA; with DataT=1, stay in IDLE and raise no error.
- DATA: shift in 8 bits LSB first, then go to PARITY.
- PARITY: capture the bit, then go to STOP.
- STOP: on strobe, go to IDLE.
REQ-020 On a STOP strobe, the byte SHALL be accepted only if DataT=1 and the data+parity bits have odd parity; otherwise the block SHALL pulse err_frame and discard the byte.
REQ-021 In any state other than IDLE, TIMEOUT_CYC cycles without a strobe SHALL force IDLE, pulse err_frame and discard the partial byte.
REQ-022 Prefix handling on accepted bytes:
- 8'hE0 sets ext.
- 8'hF0 sets brk.
- Any other byte forms event {brk, ext, byte}, then clears ext and brk.
- Prefixes produce no event.
REQ-023 Event outputs SHALL update in the cycle after the STOP strobe (latency 1).
REQ-024 A non-extended make event (ext=0, brk=0) whose byte equals KEY_CODES[i] SHALL set mAccion[i]. bandera SHALL pulse only if mAccion[i] was 0, so typematic repeats do not pulse.
REQ-025 A non-extended break event (ext=0, brk=1) on KEY_CODES[i] SHALL clear mAccion[i]; bandera stays 0.
REQ-026 If a code matches several entries of KEY_CODES, the lowest index wins.
REQ-027 Every event, mapped or not, SHALL be pushed into the FIFO.
REQ-028 FIFO behaviour:
- Push while full with no pop: drop the event and set ovf.
- Push and pop in the same cycle while full: both succeed.
- Pop while empty: ignored.
REQ-029 evt_data SHALL be stable while evt_valid=1 and evt_ready=0.

Reset
REQ-030 Reset SHALL force, at any time including mid-frame:
- FSM to IDLE, ext=0, brk=0, FIFO empty.
- mAccion=0, bandera=0, evt_valid=0, evt_data=0, err_frame=0, ovf=0.
- Filter and synchronizer state to 1 (bus idle).
REQ-031 After Reset deasserts, the first accepted frame SHALL be one whose start bit falls entirely after deassertion.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding and the constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
REQ-033 The event FIFO SHALL be a separate sub-module, ps2_evt_fifo, parameterised by depth and width.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Frame 8'h4D with valid parity -> mAccion=5'b00001 and bandera pulses once; FIFO gets {0,0,4D}.
- Sequence F0,4D -> mAccion=0, no bandera; FIFO gets {1,0,4D}.
- 4D sent three times (typematic) -> one bandera pulse; three FIFO events.
- E0,4D -> mAccion unchanged; FIFO gets {0,1,4D}.
- Bad parity on 8'h21, then a stall > TIMEOUT_CYC after 5 bits -> two err_frame pulses, no events.
- Five events with evt_ready=0 at depth 4 -> ovf=1 and the four oldest events are retained; Reset mid-frame -> all outputs 0.

Source files
------------

// File: rtl/ps2_action_decoder_pkg.sv
// Shared definitions for the PS/2 action decoder: frame FSM encoding,
// scan-code prefixes and the event word layout.
package ps2_action_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frameStateT;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Event word is {brk, ext, code[7:0]}
  localparam int EVT_W = 10;

  function automatic logic oddParityOk(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_action_decoder_evt_fifo.sv
// Small synchronous event queue with first-word-fall-through output and a
// sticky overflow flag for pushes that had to be dropped.
module ps2_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             ClockT,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] headData,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic             empty;
  logic             full;
  logic             doPush;
  logic             doPop;

  function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign doPop  = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle
  assign doPush = push && (!full || doPop);

  assign valid    = !empty;
  assign headData = empty ? '0 : mem[rdPtr];

  always_ff @(posedge ClockT) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge ClockT or posedge Reset) begin
    if (Reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (doPush) wrPtr <= nextPtr(wrPtr);
      if (doPop)  rdPtr <= nextPtr(rdPtr);
      if (push && !doPush) overflow <= 1'b1;
      unique case ({doPush, doPop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_action_decoder.sv
// PS/2 keyboard receiver that tracks held action keys, pulses on new presses
// and queues every decoded make/break event.
module ps2_action_decoder
  import ps2_action_decoder_pkg::*;
#(
  parameter int                 N_ACT       = 5,
  parameter logic [N_ACT*8-1:0] KEY_CODES   = {8'h4C, 8'h4B, 8'h22, 8'h21, 8'h4D},
  parameter int                 FILT_LEN    = 4,
  parameter int                 TIMEOUT_CYC = 50000,
  parameter int                 FIFO_DEPTH  = 4
) (
  input  logic             ClockT,
  input  logic             Reset,
  input  logic             Ps2Clk,
  input  logic             DataT,
  output logic [N_ACT-1:0] mAccion,
  output logic             bandera,
  output logic             evt_valid,
  output logic [EVT_W-1:0] evt_data,
  input  logic             evt_ready,
  output logic             err_frame,
  output logic             ovf
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0]    FILT_LAST = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0]    TIMER_MAX = TW'(TIMEOUT_CYC - 1);
  localparam logic [N_ACT-1:0] ONE       = N_ACT'(1);

  logic [1:0]       clkSync;
  logic [1:0]       dataSync;
  logic             clkS;
  logic             dataS;
  logic [FW-1:0]    filtCnt;
  logic             filtClk;
  logic             strobe;

  frameStateT       state;
  logic [2:0]       bitCnt;
  logic [7:0]       shiftReg;
  logic             parityBit;
  logic [TW-1:0]    timer;
  logic             armed;
  logic             ext;
  logic             brk;

  logic             strobeArmed;
  logic             timeoutHit;
  logic             byteOk;
  logic             isPrefix;
  logic             evtPush;
  logic [N_ACT-1:0] keyHit;
  logic [N_ACT-1:0] keyFirst;

  always_ff @(posedge ClockT or posedge Reset) begin
    if (Reset) begin
      clkSync  <= 2'b11;
      dataSync <= 2'b11;
    end else begin
      clkSync  <= {clkSync[0], Ps2Clk};
      dataSync <= {dataSync[0], DataT};
    end
  end

  assign clkS  = clkSync[1];
  assign dataS = dataSync[1];

  // Accept a new clock level only after FILT_LEN consecutive differing samples;
  // the strobe marks a 1->0 change of the accepted level.
  always_ff @(posedge ClockT or posedge Reset) begin
    if (Reset) begin
      filtCnt <= '0;
      filtClk <= 1'b1;
      strobe  <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (clkS == filtClk) begin
        filtCnt <= '0;
      end else if (filtCnt == FILT_LAST) begin
        filtCnt <= '0;
        filtClk <= clkS;
        strobe  <= filtClk;
      end else begin
        filtCnt <= filtCnt + FW'(1);
      end
    end
  end

  assign strobeArmed = strobe && armed;
  assign timeoutHit  = (state != ST_IDLE) && !strobe && (timer == TIMER_MAX);
  assign byteOk      = strobeArmed && (state == ST_STOP) && dataS &&
                       oddParityOk(shiftReg, parityBit);
  assign isPrefix    = (shiftReg == PS2_EXT) || (shiftReg == PS2_BRK);
  assign evtPush     = byteOk && !isPrefix;

  // Lowest matching index wins: isolate the least significant set bit
  always_comb begin
    keyHit = '0;
    for (int i = 0; i < N_ACT; i++) begin
      keyHit[i] = (KEY_CODES[8*i +: 8] == shiftReg);
    end
    keyFirst = keyHit & (~keyHit + ONE);
  end

  // Until the bus has been seen idle for a full timeout window after reset,
  // strobes are ignored so the tail of an interrupted frame cannot be taken
  // for a fresh start bit. Afterwards the same timer guards in-frame stalls.
  always_ff @(posedge ClockT or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      bitCnt    <= '0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
      timer     <= '0;
      armed     <= 1'b0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      mAccion   <= '0;
      bandera   <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      bandera   <= 1'b0;
      err_frame <= 1'b0;

      if (!armed) begin
        if (!filtClk) begin
          timer <= '0;
        end else if (timer == TIMER_MAX) begin
          timer <= '0;
          armed <= 1'b1;
        end else begin
          timer <= timer + TW'(1);
        end
      end else if ((state == ST_IDLE) || strobe || timeoutHit) begin
        timer <= '0;
      end else begin
        timer <= timer + TW'(1);
      end

      if (timeoutHit) begin
        state     <= ST_IDLE;
        err_frame <= 1'b1;
      end else if (strobeArmed) begin
        unique case (state)
          ST_IDLE: begin
            if (!dataS) begin
              state  <= ST_DATA;
              bitCnt <= '0;
            end
          end
          ST_DATA: begin
            shiftReg <= {dataS, shiftReg[7:1]};
            bitCnt   <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            parityBit <= dataS;
            state     <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (!byteOk) err_frame <= 1'b1;
          end
        endcase
      end

      if (byteOk) begin
        if (shiftReg == PS2_EXT) begin
          ext <= 1'b1;
        end else if (shiftReg == PS2_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (!ext) begin
            if (!brk) begin
              mAccion <= mAccion | keyFirst;
              bandera <= |(keyFirst & ~mAccion);
            end else begin
              mAccion <= mAccion & ~keyFirst;
            end
          end
        end
      end
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) evtFifo (
    .ClockT   (ClockT),
    .Reset    (Reset),
    .push     (evtPush),
    .pushData ({brk, ext, shiftReg}),
    .pop      (evt_ready),
    .valid    (evt_valid),
    .headData (evt_data),
    .overflow (ovf)
  );

endmodule
